// File: rtl/clk_mode_pkg.sv
// Shared types and defaults for the run-clock mode controller.
// Optional auto-revert feature is enabled with CLK_MODE_AUTOREVERT_EN.
package clk_mode_pkg;

    typedef enum logic {
        SLOW = 1'b0,
        FAST = 1'b1
    } clk_mode_e;

    localparam int unsigned DEB_CYCLES_DEF   = 500000;
    localparam int unsigned FAST_TIMEOUT_DEF = 50000000;
    localparam int unsigned FAST_CNT_W       = 32;

    // Next mode on a toggle event.
    function automatic clk_mode_e toggle_mode(input clk_mode_e mode);
        return (mode == FAST) ? SLOW : FAST;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-run debouncer and press pulse generator
// for the mode push-button.
module btn_debounce
    import clk_mode_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic primitive_clk,
    input  logic rst_n,
    input  logic mode_btn,
    output logic btn_level,
    output logic press_pulse
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] deb_cnt;
    logic             level_d;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge primitive_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= mode_btn;
            s2 <= s1;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge primitive_clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt   <= '0;
            btn_level <= 1'b0;
        end else if (s2 == btn_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CNT_LAST) begin
            btn_level <= s2;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
        end
    end

    // One-cycle pulse in the cycle after the debounced level rises.
    always_ff @(posedge primitive_clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d     <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            level_d     <= btn_level;
            press_pulse <= btn_level & ~level_d;
        end
    end

endmodule

// File: rtl/clk_mode_ctrl.sv
// Mode push-button to clk_switch level: debounce then SLOW/FAST toggle FSM.
// Define CLK_MODE_AUTOREVERT_EN to return to SLOW after FAST_TIMEOUT cycles.
module clk_mode_ctrl
    import clk_mode_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int unsigned FAST_TIMEOUT = FAST_TIMEOUT_DEF
) (
    input  logic primitive_clk,
    input  logic rst_n,
    input  logic mode_btn,
    output logic btn_level,
    output logic press_pulse,
    output logic clk_switch
);

    clk_mode_e state;
    logic      timeout_c;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .primitive_clk (primitive_clk),
        .rst_n         (rst_n),
        .mode_btn      (mode_btn),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse)
    );

`ifdef CLK_MODE_AUTOREVERT_EN
    localparam logic [FAST_CNT_W-1:0] FAST_LAST = FAST_CNT_W'(FAST_TIMEOUT - 1);

    logic [FAST_CNT_W-1:0] fast_cnt;

    assign timeout_c = (state == FAST) && (fast_cnt == FAST_LAST);

    // Cycles spent in FAST; zero in SLOW so every entry starts from 0.
    always_ff @(posedge primitive_clk or negedge rst_n) begin
        if (!rst_n) begin
            fast_cnt <= '0;
        end else if ((state == FAST) && !press_pulse && !timeout_c) begin
            fast_cnt <= fast_cnt + FAST_CNT_W'(1);
        end else begin
            fast_cnt <= '0;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^FAST_TIMEOUT;
    assign timeout_c      = 1'b0;
`endif

    // Press and timeout coinciding in FAST is a single toggle back to SLOW.
    always_ff @(posedge primitive_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOW;
        end else if (press_pulse || timeout_c) begin
            state <= toggle_mode(state);
        end
    end

    assign clk_switch = (state == FAST);

endmodule

// File: tb/tb_clk_mode_ctrl.sv
// Self-checking bench for clk_mode_ctrl with DEB_CYCLES=4, FAST_TIMEOUT=20.
module tb_clk_mode_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned FT  = 20;
`ifdef CLK_MODE_AUTOREVERT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic primitive_clk = 1'b0;
    logic rst_n         = 1'b0;
    logic mode_btn      = 1'b0;
    logic btn_level;
    logic press_pulse;
    logic clk_switch;

    int n_cmp = 0;
    int n_err = 0;

    always #5 primitive_clk = ~primitive_clk;

    clk_mode_ctrl #(
        .DEB_CYCLES   (DEB),
        .FAST_TIMEOUT (FT)
    ) dut (
        .primitive_clk (primitive_clk),
        .rst_n         (rst_n),
        .mode_btn      (mode_btn),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .clk_switch    (clk_switch)
    );

    // Reference: the input is seen two samples late; the level follows it once it has
    // disagreed for DEB samples in a row; a rise yields a pulse next cycle; each pulse
    // (or FT cycles spent fast, when enabled) flips the mode one cycle later.
    bit m_s1, m_s2, m_lvl, m_lvl_d, m_pulse, m_fast;
    int m_run, m_ft;

    always @(posedge primitive_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_lvl_d = 0; m_pulse = 0; m_fast = 0;
            m_run = 0; m_ft = 0;
        end else begin
            bit expire;
            expire = AUTO && m_fast && (m_ft == int'(FT) - 1);
            if (m_pulse || expire) begin
                m_fast = !m_fast;
                m_ft   = 0;
            end else if (m_fast) begin
                m_ft = m_ft + 1;
            end
            m_pulse = m_lvl && !m_lvl_d;
            m_lvl_d = m_lvl;
            if (m_s2 != m_lvl) begin
                m_run = m_run + 1;
                if (m_run == int'(DEB)) begin
                    m_lvl = m_s2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = mode_btn;
        end
    end

    task automatic step(input logic btn);
        mode_btn = btn;
        @(posedge primitive_clk);
        @(negedge primitive_clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        mode_btn = 1'b0;
        repeat (3) @(negedge primitive_clk);
        n_cmp++;
        if ({btn_level, press_pulse, clk_switch} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs got=%b want=000", {btn_level, press_pulse, clk_switch});
        end
        n_cmp++;
        if (dut.state !== clk_mode_pkg::SLOW) begin
            n_err++;
            $display("FAIL reset_state got=%b want=0", dut.state);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1'b0);
            n_cmp++;
            if ({btn_level, press_pulse, clk_switch} !== 3'b000) begin
                n_err++;
                $display("FAIL post_reset_idle k=%0d got=%b want=000", k, {btn_level, press_pulse, clk_switch});
            end
        end
    endtask

    task automatic test_clean_press();
        logic [2:0] want;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1);
            want = {k >= 6, k == 7, k >= 8};
            n_cmp++;
            if ({btn_level, press_pulse, clk_switch} !== want) begin
                n_err++;
                $display("FAIL clean_press k=%0d got=%b want=%b", k, {btn_level, press_pulse, clk_switch}, want);
            end
        end
        for (int k = 1; k <= 20; k++) begin
            step(1'b0);
            n_cmp++;
            if ({btn_level, press_pulse, clk_switch} !== {m_lvl, m_pulse, m_fast} || press_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL release k=%0d got=%b want=%b", k, {btn_level, press_pulse, clk_switch},
                         {m_lvl, 1'b0, m_fast});
            end
        end
    endtask

    task automatic test_bounce();
        logic [2:0] hold;
        logic       pat [4];
        pat  = '{1'b1, 1'b0, 1'b1, 1'b0};
        hold = {m_lvl, m_pulse, m_fast};
        for (int k = 0; k < 16; k++) begin
            step((k < 4) ? pat[k] : 1'b0);
            n_cmp++;
            if ({btn_level, press_pulse, clk_switch} !== hold) begin
                n_err++;
                $display("FAIL bounce k=%0d got=%b want=%b", k, {btn_level, press_pulse, clk_switch}, hold);
            end
        end
    endtask

    task automatic test_second_press();
        logic pre;
        logic [1:0] want;
        pre = m_fast;
        for (int k = 1; k <= 14; k++) begin
            step(1'b1);
            want = {k == 7, (k >= 8) ? !pre : pre};
            n_cmp++;
            if ({press_pulse, clk_switch} !== want) begin
                n_err++;
                $display("FAIL second_press k=%0d got=%b want=%b", k, {press_pulse, clk_switch}, want);
            end
        end
        for (int k = 1; k <= 32; k++) begin
            step(1'b0);
            n_cmp++;
            if ({btn_level, press_pulse, clk_switch} !== {m_lvl, m_pulse, m_fast}) begin
                n_err++;
                $display("FAIL second_release k=%0d got=%b want=%b", k, {btn_level, press_pulse, clk_switch},
                         {m_lvl, m_pulse, m_fast});
            end
        end
    endtask

`ifdef CLK_MODE_AUTOREVERT_EN
    task automatic test_autorevert();
        logic [1:0] want;
        for (int k = 1; k <= 40; k++) begin
            step(k <= 12);
            n_cmp++;
            if (clk_switch !== (k >= 8 && k <= 27)) begin
                n_err++;
                $display("FAIL autorevert_idle k=%0d got=%b want=%b", k, clk_switch, (k >= 8 && k <= 27));
            end
        end
        // Second press pulses exactly on the timeout cycle: one fall, no re-rise.
        for (int k = 1; k <= 45; k++) begin
            step((k <= 10) || (k >= 21));
            want = {k == 7 || k == 27, k >= 8 && k <= 27};
            n_cmp++;
            if ({press_pulse, clk_switch} !== want) begin
                n_err++;
                $display("FAIL autorevert_collide k=%0d got=%b want=%b", k, {press_pulse, clk_switch}, want);
            end
        end
        for (int k = 1; k <= 20; k++) begin
            step(1'b0);
            n_cmp++;
            if ({btn_level, press_pulse, clk_switch} !== {m_lvl, m_pulse, m_fast}) begin
                n_err++;
                $display("FAIL autorevert_release k=%0d got=%b want=%b", k, {btn_level, press_pulse, clk_switch},
                         {m_lvl, m_pulse, m_fast});
            end
        end
    endtask
`endif

    task automatic test_midop_reset();
        logic [2:0] want;
        int pulses;
        for (int k = 1; k <= 24; k++) begin
            step((k <= 10) || (k >= 21));
            n_cmp++;
            if ({btn_level, press_pulse, clk_switch} !== {m_lvl, m_pulse, m_fast}) begin
                n_err++;
                $display("FAIL midop_setup k=%0d got=%b want=%b", k, {btn_level, press_pulse, clk_switch},
                         {m_lvl, m_pulse, m_fast});
            end
        end
        n_cmp++;
        if ({clk_switch, dut.u_deb.deb_cnt} !== 3'b110) begin
            n_err++;
            $display("FAIL midop_precond got=%b want=110", {clk_switch, dut.u_deb.deb_cnt});
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({btn_level, press_pulse, clk_switch} !== 3'b000) begin
            n_err++;
            $display("FAIL midop_async_clear got=%b want=000", {btn_level, press_pulse, clk_switch});
        end
        repeat (3) step(1'b1);
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 15; k++) begin
            step(1'b1);
            pulses += int'(press_pulse);
            want = {k >= 6, k == 7, k >= 8};
            n_cmp++;
            if ({btn_level, press_pulse, clk_switch} !== want) begin
                n_err++;
                $display("FAIL midop_held_release k=%0d got=%b want=%b", k, {btn_level, press_pulse, clk_switch}, want);
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL midop_pulse_count got=%0d want=1", pulses);
        end
        repeat (30) step(1'b0);
    endtask

    task automatic test_random();
        logic btn;
        int   len;
        for (int r = 0; r < 90; r++) begin
            btn = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 30)) : int'($urandom_range(1, 4));
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                step(btn);
                rst_n = 1'b1;
            end
            for (int k = 0; k < len; k++) begin
                step(btn);
                n_cmp++;
                if ({btn_level, press_pulse, clk_switch} !== {m_lvl, m_pulse, m_fast}) begin
                    n_err++;
                    $display("FAIL random r=%0d k=%0d got=%b want=%b", r, k, {btn_level, press_pulse, clk_switch},
                             {m_lvl, m_pulse, m_fast});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_second_press();
`ifdef CLK_MODE_AUTOREVERT_EN
        test_autorevert();
`endif
        test_midop_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
